gb_cpu_schedule_sequencer: RTL
==============================

# gb_cpu_schedule_sequencer

Control-unit sequencer that consumes the per-instruction `schedule_t` produced by the decoder package and plays it out one M-cycle at a time. It latches the decoded schedule after each opcode fetch, steps a slot index on every M-cycle strobe, and presents the active slot's control word to the datapath (register file, IDU, ALU, bus interface). It resolves conditional early termination (`cc_check`) and tracks the CB-prefix decode mode.

## Interface
Parameters:
- `MAX_SLOTS`, 6: number of `instruction_controls` entries in `schedule_t`; the slot index is 3 bits.

Ports (clock `clk` single domain; reset `reset` asynchronous, active-high):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous active-high reset
- `m_tick`  in  1  M-cycle advance strobe; legal spacing ≥2 clocks
- `flags_i`  in  4  {Z,N,H,C} from the register file
- `decoded_schedule_i`  in  `schedule_t`  combinational decoder output for current IR and `cb_mode_o`
- `controls_o`  out  `instr_ctrl_t`  active slot control word
- `m_cycle_o`  out  3  active slot index
- `bit_cmd_o`  out  1  latched `schedule.bit_cmd`
- `cb_mode_o`  out  1  decoder selects CB table when 1
- `cc_taken_o`  out  1  result of most recent `cc_check` in this instruction
- `busy_load_o`  out  1  high during LOAD state

## Operation
- States: EXEC, LOAD. Registers: `sched_q`, `idx`, `cb_q`, `cc_q`.
- Reset: state EXEC, `sched_q` = `RESET_SCHEDULE` (m_cycles=0, slot0 = fetch: addr PC → IR, IDU INC PC, all wren/ALU/interrupt/rst/cc bits 0), `idx`=0, `cb_mode_o`=0, `cc_taken_o`=0, `bit_cmd_o`=0, `busy_load_o`=0; `controls_o` = `RESET_SCHEDULE` slot0.
- EXEC, `m_tick`, `idx` == last (`min(sched_q.m_cycles,5)`): `cb_q` ← `sched_q.cb_prefix_next`; go LOAD. IR is written by datapath on this same tick.
- EXEC, `m_tick`, slot `cc_check`=1, not last: evaluate `sched_q.condition` (CC_NZ:!Z, CC_Z:Z, CC_NC:!C, CC_C:C); `cc_q` ← result; true → `idx`+1; false → `idx` ← last.
- EXEC, `m_tick`, otherwise: `idx`+1. `cc_check` on last slot is ignored.
- LOAD (exactly one clock, no tick required): `sched_q` ← `decoded_schedule_i`, `idx` ← 0, `cc_q` ← 0; go EXEC.
- `controls_o` = `sched_q.instruction_controls[idx]` in EXEC; `IDLE_CTRL` (all wren/drive/enable bits 0) in LOAD.
- `m_tick` in LOAD is a protocol violation: ignored, state still advances to EXEC.
- `m_cycles` values 6–7 clamp to 5.
- Reset mid-instruction aborts immediately to reset values.

## Timing
- All outputs registered or decoded from registers; no combinational path from `flags_i` or `decoded_schedule_i` to outputs.
- Instruction with `m_cycles`=N occupies N+1 ticks plus one LOAD clock between ticks.
- `cb_mode_o` changes on the same edge that writes IR, so the decoder has one full clock before LOAD samples it.
- `flags_i` sampled at the `cc_check` tick edge (includes ALU result of earlier slots).

## Structure
- `gb_cpu_common_pkg`: `instr_ctrl_t` (slot element of `schedule_t`), `condition_code_t` CC_NZ/CC_Z/CC_NC/CC_C, `RESET_SCHEDULE`, `IDLE_CTRL` constants, sequencer state enum.
- Condition evaluation is a function `ccEval(condition_code_t, flags)` in the common package; there is no sub-module.

## Test plan
- Reset then release → `controls_o` = fetch slot, `m_cycle_o`=0. One tick → `busy_load_o`=1 for 1 clk, then adopts decoder schedule.
- Back-to-back `m_cycles`=0 ADD A,B schedules, 5 ticks → `m_cycle_o` stays 0, five LOAD pulses, `alu_wren`=1 in each.
- `m_cycles`=2 schedule → `m_cycle_o` 0,1,2 on successive ticks, then LOAD.
- JR NZ (`m_cycles`=2, `cc_check` slot0). Z=1 → indices 0,2, `cc_taken_o`=0. Z=0 → 0,1,2, `cc_taken_o`=1.
- Schedule with `cb_prefix_next`=1 ends → `cb_mode_o`=1 through the next instruction; it returns to 0 after that instruction's final tick.
- Assert `reset` at `m_cycle_o`=2 between clock edges → all outputs take reset values before the next edge. `m_tick` in LOAD → ignored, no index skip.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared control-unit types: per-slot control word, decoded schedule,
// condition codes, sequencer state and the reset/idle constants.
package gb_cpu_common_pkg;

    localparam int SCHED_SLOTS = 6;

    typedef enum logic [1:0] {CC_NZ, CC_Z, CC_NC, CC_C} condition_code_t;
    typedef enum logic [1:0] {ADDR_PC, ADDR_SP, ADDR_HL, ADDR_WZ} addr_sel_t;
    typedef enum logic [1:0] {IDU_NONE, IDU_INC, IDU_DEC} idu_op_t;
    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR,
        ALU_CP, ALU_INC, ALU_DEC, ALU_ROT, ALU_BIT, ALU_RES, ALU_SET, ALU_DAA
    } alu_op_t;

    // One M-cycle worth of datapath controls
    typedef struct packed {
        addr_sel_t addr_sel;
        logic      addr_en;
        logic      ir_wren;
        idu_op_t   idu_op;
        logic      pc_wren;
        logic [3:0] reg_wren;
        logic      alu_wren;
        alu_op_t   alu_op;
        logic      mem_rd;
        logic      mem_wr;
        logic      ime_set;
        logic      ime_clr;
        logic      rst_vec;
        logic      cc_check;
    } instr_ctrl_t;

    // Whole-instruction plan produced by the decoder
    typedef struct packed {
        logic [2:0]      m_cycles;
        condition_code_t condition;
        logic            bit_cmd;
        logic            cb_prefix_next;
        instr_ctrl_t [SCHED_SLOTS-1:0] instruction_controls;
    } schedule_t;

    typedef enum logic {SEQ_EXEC, SEQ_LOAD} seq_state_t;

    localparam instr_ctrl_t IDLE_CTRL = '0;

    // Opcode fetch: drive PC onto the bus, capture IR, post-increment PC
    localparam instr_ctrl_t FETCH_CTRL = '{
        addr_sel: ADDR_PC, addr_en: 1'b1, ir_wren: 1'b1, idu_op: IDU_INC,
        pc_wren: 1'b1, reg_wren: 4'h0, alu_wren: 1'b0, alu_op: ALU_NOP,
        mem_rd: 1'b1, mem_wr: 1'b0, ime_set: 1'b0, ime_clr: 1'b0,
        rst_vec: 1'b0, cc_check: 1'b0
    };

    localparam schedule_t RESET_SCHEDULE = '{
        m_cycles: 3'd0, condition: CC_NZ, bit_cmd: 1'b0, cb_prefix_next: 1'b0,
        instruction_controls: {{(SCHED_SLOTS-1){IDLE_CTRL}}, FETCH_CTRL}
    };

    // flags = {Z,N,H,C}
    function automatic logic ccEval(condition_code_t cc, logic [3:0] flags);
        logic r;
        r = 1'b0;
        case (cc)
            CC_NZ:   r = !flags[3];
            CC_Z:    r = flags[3];
            CC_NC:   r = !flags[0];
            CC_C:    r = flags[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gb_cpu_schedule_sequencer.sv
// Plays a decoded instruction schedule out one M-cycle per tick, with
// conditional early exit and CB-prefix mode tracking.
module gb_cpu_schedule_sequencer
    import gb_cpu_common_pkg::*;
#(
    parameter int MAX_SLOTS = SCHED_SLOTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_tick,
    input  logic [3:0]  flags_i,
    input  schedule_t   decoded_schedule_i,
    output instr_ctrl_t controls_o,
    output logic [2:0]  m_cycle_o,
    output logic        bit_cmd_o,
    output logic        cb_mode_o,
    output logic        cc_taken_o,
    output logic        busy_load_o
);

    localparam logic [2:0] LAST_SLOT = 3'(MAX_SLOTS - 1);

    seq_state_t  state, nextState;
    schedule_t   sched_q;
    logic [2:0]  idx;
    logic        cb_q;
    logic        cc_q;

    logic [2:0]  lastIdx;
    instr_ctrl_t slotCtrl;
    logic        ccResult;
    logic        atLast;

    // Decode of current slot, clamped final index and condition result
    always_comb begin
        lastIdx  = (sched_q.m_cycles > LAST_SLOT) ? LAST_SLOT : sched_q.m_cycles;
        slotCtrl = sched_q.instruction_controls[idx];
        ccResult = ccEval(sched_q.condition, flags_i);
        atLast   = (idx == lastIdx);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEQ_EXEC;
        else       state <= nextState;
    end

    // Next state: final tick opens a one-clock LOAD, LOAD always returns
    always_comb begin
        nextState = state;
        case (state)
            SEQ_EXEC: if (m_tick && atLast) nextState = SEQ_LOAD;
            SEQ_LOAD: nextState = SEQ_EXEC;
            default:  nextState = SEQ_EXEC;
        endcase
    end

    // Schedule, slot index, CB mode and condition result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sched_q <= RESET_SCHEDULE;
            idx     <= 3'd0;
            cb_q    <= 1'b0;
            cc_q    <= 1'b0;
        end else if (state == SEQ_LOAD) begin
            // A stray tick here is ignored; the new schedule starts at slot 0
            sched_q <= decoded_schedule_i;
            idx     <= 3'd0;
            cc_q    <= 1'b0;
        end else if (m_tick) begin
            if (atLast) begin
                // Same edge as the IR write, so the decoder sees the new mode
                cb_q <= sched_q.cb_prefix_next;
            end else if (slotCtrl.cc_check) begin
                cc_q <= ccResult;
                idx  <= ccResult ? idx + 3'd1 : lastIdx;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Outputs decoded purely from registers
    always_comb begin
        controls_o  = (state == SEQ_EXEC) ? slotCtrl : IDLE_CTRL;
        m_cycle_o   = idx;
        bit_cmd_o   = sched_q.bit_cmd;
        cb_mode_o   = cb_q;
        cc_taken_o  = cc_q;
        busy_load_o = (state == SEQ_LOAD);
    end

endmodule
